sipo_frame_ctrl: RTL

Frame controller for the serial-in/parallel-out shift path. It arms on a frame-start strobe and shifts exactly N qualified serial bits. It then presents the assembled word on a registered parallel output with a valid/ready handshake. It also flags protocol errors. It sits between a serial bit source and any parallel consumer, and owns the shift-enable and output-enable sequencing that the bare shift register leaves to its caller.

---
 rtl/sipo_pkg.sv | 21 ++
 rtl/sipo_shreg.sv | 38 +++
 rtl/sipo_frame_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_pkg
// Description : Shared types and constants for the SIPO frame controller.
//               - state_t          : frame controller state encoding (2 bits)
//               - c_DEFAULT_WIDTH  : default assembled word width
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

    // Frame controller states; encoding is fixed so it can be probed in debug.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int c_DEFAULT_WIDTH = 4;

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_shreg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shreg
// Description : N-bit left-shifting register, serial data enters bit 0.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_shift_en    - shift i_din in this cycle
//               i_clr         - synchronous clear (takes priority over shift)
//               i_din         - serial data bit
//               o_q           - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shreg #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_shift_en,
    input  logic         i_clr,
    input  logic         i_din,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_shift_en) begin
            r_q <= {r_q[N-2:0], i_din};
        end
    end

    assign o_q = r_q;

endmodule : sipo_shreg
`default_nettype wire

// File: rtl/sipo_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sipo_frame_ctrl
// Description : Frame controller around a SIPO shift register. Arms on start,
//               collects N qualified serial bits (MSB first), presents the
//               word on a registered output with valid/ready handshake, and
//               keeps sticky overrun / frame-error flags.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               start          - frame-start strobe
//               bit_valid      - serial_in carries a data bit this cycle
//               serial_in      - serial data bit
//               out_ready      - consumer accepts the word
//               clr_err        - clears the sticky error flags
//               parallel_out   - assembled word (stable while out_valid)
//               out_valid      - parallel_out holds a complete word
//               busy           - high in SHIFT and HOLD
//               bit_cnt        - bits received in the current frame
//               overrun        - sticky: bit dropped while holding a word
//               frame_err      - sticky: frame restarted by a mid-frame start
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_frame_ctrl
    import sipo_pkg::*;
#(
    parameter int N  = c_DEFAULT_WIDTH,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          serial_in,
    input  logic          out_ready,
    input  logic          clr_err,
    output logic [N-1:0]  parallel_out,
    output logic          out_valid,
    output logic          busy,
    output logic [CW-1:0] bit_cnt,
    output logic          overrun,
    output logic          frame_err
);

    localparam logic [CW-1:0] c_LAST_CNT = CW'(N - 1);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_bit_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [N-1:0]  r_parallel_out;
    logic          r_out_valid;
    logic          w_out_valid_next;
    logic          r_busy;
    logic          r_overrun;
    logic          r_frame_err;
    logic          w_shift_en;
    logic          w_shreg_clr;
    logic          w_load;
    logic          w_overrun_evt;
    logic          w_frame_err_evt;
    logic [N-1:0]  w_shreg_q;

    sipo_shreg #(
        .N (N)
    ) u_shreg (
        .clk        (clk),
        .rst        (rst),
        .i_shift_en (w_shift_en),
        .i_clr      (w_shreg_clr),
        .i_din      (serial_in),
        .o_q        (w_shreg_q)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state     = r_state;
        w_cnt_next       = r_bit_cnt;
        w_out_valid_next = r_out_valid;
        w_shift_en       = 1'b0;
        w_shreg_clr      = 1'b0;
        w_load           = 1'b0;
        w_overrun_evt    = 1'b0;
        w_frame_err_evt  = 1'b0;

        case (r_state)
            IDLE: begin
                // bit_valid is deliberately ignored here, even alongside start.
                if (start) begin
                    w_next_state = SHIFT;
                    w_cnt_next   = '0;
                    w_shreg_clr  = 1'b1;
                end
            end

            SHIFT: begin
                if (start) begin
                    // Restart: the partial word and any coincident bit are lost.
                    w_cnt_next      = '0;
                    w_shreg_clr     = 1'b1;
                    w_frame_err_evt = 1'b1;
                end else if (bit_valid) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == c_LAST_CNT) begin
                        // Last bit goes straight into the output register so the
                        // word is visible right after its final sampling edge.
                        w_load           = 1'b1;
                        w_out_valid_next = 1'b1;
                        w_cnt_next       = '0;
                        w_next_state     = HOLD;
                    end else begin
                        w_cnt_next = r_bit_cnt + c_CNT_ONE;
                    end
                end
            end

            HOLD: begin
                if (bit_valid) begin
                    w_overrun_evt = 1'b1;
                end
                if (r_out_valid && out_ready) begin
                    w_out_valid_next = 1'b0;
                    if (start) begin
                        w_next_state = SHIFT;
                        w_cnt_next   = '0;
                        w_shreg_clr  = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end

            default: begin
                w_next_state     = IDLE;
                w_cnt_next       = '0;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counter, output register, busy and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt      <= '0;
            r_parallel_out <= '0;
            r_out_valid    <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_bit_cnt   <= w_cnt_next;
            r_out_valid <= w_out_valid_next;
            r_busy      <= (w_next_state != IDLE);

            if (w_load) begin
                r_parallel_out <= {w_shreg_q[N-2:0], serial_in};
            end

            // A new error event outranks a coincident clear.
            if (w_overrun_evt) begin
                r_overrun <= 1'b1;
            end else if (clr_err) begin
                r_overrun <= 1'b0;
            end

            if (w_frame_err_evt) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign parallel_out = r_parallel_out;
    assign out_valid    = r_out_valid;
    assign busy         = r_busy;
    assign bit_cnt      = r_bit_cnt;
    assign overrun      = r_overrun;
    assign frame_err    = r_frame_err;

endmodule : sipo_frame_ctrl
`default_nettype wire
